// File: rtl/rr_arb_pkg.sv
// Shared constants and helpers for the round-robin FIFO arbiter.
// Width constants describe the default 4-channel, 4-deep configuration.
package rr_arb_pkg;

    localparam int NCH_DEF   = 4;
    localparam int DEPTH_DEF = 4;
    localparam int CW        = $clog2(NCH_DEF);
    localparam int AW        = $clog2(DEPTH_DEF);

    // Round-robin pointer value after reset.
    localparam int CNT_RST   = 0;

    function automatic int next_ptr(input int cur, input int n);
        return (cur >= n - 1) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy count.
// A push to a full FIFO or a pop from an empty FIFO is ignored.
module sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int NW = PW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [NW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == NW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        if (do_push && !do_pop) begin
            count_d = count_q + NW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - NW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/param_rr_fifo_arbiter.sv
// N-channel round-robin arbiter draining per-channel FIFOs into one registered output.
// Define RR_SKIP_EMPTY_EN for work-conserving arbitration; default is fixed slot rotation.
module param_rr_fifo_arbiter
    import rr_arb_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NCH-1:0]           wen,
    input  logic [NCH*DW-1:0]        din,
    input  logic                     ready,
    output logic [DW-1:0]            dout,
    output logic                     valid,
    output logic [$clog2(NCH)-1:0]   grant_id,
    output logic [$clog2(NCH)-1:0]   counter,
    output logic [NCH-1:0]           full,
    output logic [NCH-1:0]           ovf
);

    localparam int CH_W = $clog2(NCH);

    logic [NCH-1:0]  pop;
    logic [NCH-1:0]  fifo_full;
    logic [NCH-1:0]  fifo_empty;
    logic [DW-1:0]   head [NCH];

    logic [DW-1:0]   dout_q, dout_d;
    logic            valid_q, valid_d;
    logic [CH_W-1:0] grant_q, grant_d;
    logic [CH_W-1:0] counter_q, counter_d;
    logic [NCH-1:0]  ovf_q, ovf_d;
    logic            load;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        sync_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (wen[i]),
            .pop   (pop[i]),
            .wdata (din[i*DW +: DW]),
            .head  (head[i]),
            .full  (fifo_full[i]),
            .empty (fifo_empty[i])
        );
    end

    // Output register is free when it holds nothing or the consumer takes it now.
    assign load  = !valid_q || ready;
    assign ovf_d = wen & fifo_full;

    always_comb begin
        pop       = '0;
        dout_d    = dout_q;
        valid_d   = valid_q;
        grant_d   = grant_q;
        counter_d = counter_q;
        if (load) begin
            valid_d = 1'b0;
`ifdef RR_SKIP_EMPTY_EN
            begin
                logic found;
                int   idx;
                found = 1'b0;
                for (int k = 0; k < NCH; k++) begin
                    idx = (int'(counter_q) + k) % NCH;
                    if (!found && !fifo_empty[idx]) begin
                        found     = 1'b1;
                        pop[idx]  = 1'b1;
                        valid_d   = 1'b1;
                        dout_d    = head[idx];
                        grant_d   = CH_W'(idx);
                        counter_d = CH_W'(next_ptr(idx, NCH));
                    end
                end
            end
`else
            counter_d = CH_W'(next_ptr(int'(counter_q), NCH));
            for (int k = 0; k < NCH; k++) begin
                if (counter_q == CH_W'(k) && !fifo_empty[k]) begin
                    pop[k]  = 1'b1;
                    valid_d = 1'b1;
                    dout_d  = head[k];
                    grant_d = CH_W'(k);
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q    <= '0;
            valid_q   <= 1'b0;
            grant_q   <= '0;
            counter_q <= CH_W'(CNT_RST);
            ovf_q     <= '0;
        end else begin
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            grant_q   <= grant_d;
            counter_q <= counter_d;
            ovf_q     <= ovf_d;
        end
    end

    assign dout     = dout_q;
    assign valid    = valid_q;
    assign grant_id = grant_q;
    assign counter  = counter_q;
    assign full     = fifo_full;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_param_rr_fifo_arbiter.sv
// Directed scoreboard bench: default 4x8x4 arbiter plus a 3-channel 16-bit 8-deep instance.
module tb_param_rr_fifo_arbiter;

    localparam int NCH    = 4;
    localparam int DW     = 8;
    localparam int DEPTH  = 4;
    localparam int NCH6   = 3;
    localparam int DW6    = 16;
    localparam int DEPTH6 = 8;

`ifdef RR_SKIP_EMPTY_EN
    localparam int SYNC0 = 0;
    localparam int SYNC6 = 0;
    localparam int NBUB  = 0;
`else
    localparam int SYNC0 = 3;
    localparam int SYNC6 = 2;
    localparam int NBUB  = 3;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NCH-1:0]      wen;
    logic [NCH*DW-1:0]   din;
    logic                ready;
    logic [DW-1:0]       dout;
    logic                valid;
    logic [1:0]          grant_id;
    logic [1:0]          counter;
    logic [NCH-1:0]      full;
    logic [NCH-1:0]      ovf;

    logic [NCH6-1:0]     wen6;
    logic [NCH6*DW6-1:0] din6;
    logic                ready6;
    logic [DW6-1:0]      dout6;
    logic                valid6;
    logic [1:0]          grant6;
    logic [1:0]          counter6;
    logic [NCH6-1:0]     full6;
    logic [NCH6-1:0]     ovf6;

    typedef struct {
        logic [15:0] d;
        int          g;
    } exp_t;

    exp_t sb0[$];
    exp_t sb6[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    param_rr_fifo_arbiter #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wen      (wen),
        .din      (din),
        .ready    (ready),
        .dout     (dout),
        .valid    (valid),
        .grant_id (grant_id),
        .counter  (counter),
        .full     (full),
        .ovf      (ovf)
    );

    param_rr_fifo_arbiter #(.NCH(NCH6), .DW(DW6), .DEPTH(DEPTH6)) u_dut6 (
        .clk      (clk),
        .rst_n    (rst_n),
        .wen      (wen6),
        .din      (din6),
        .ready    (ready6),
        .dout     (dout6),
        .valid    (valid6),
        .grant_id (grant6),
        .counter  (counter6),
        .full     (full6),
        .ovf      (ovf6)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop0();
        exp_t e;
        chk("sb0_extra_word", 32'(sb0.size() > 0), 32'd1);
        if (sb0.size() > 0) begin
            e = sb0.pop_front();
            chk("dout", 32'(dout), 32'(e.d));
            chk("grant_id", 32'(grant_id), 32'(e.g));
            chk("counter_after_grant", 32'(counter), 32'((e.g + 1) % NCH));
        end
    endtask

    task automatic pop6();
        exp_t e;
        chk("sb6_extra_word", 32'(sb6.size() > 0), 32'd1);
        if (sb6.size() > 0) begin
            e = sb6.pop_front();
            chk("dout6", 32'(dout6), 32'(e.d));
            chk("grant6", 32'(grant6), 32'(e.g));
            chk("counter6_after_grant", 32'(counter6), 32'((e.g + 1) % NCH6));
        end
    endtask

    // Consumes any handshake pending at the coming edge, then advances one cycle.
    task automatic tick();
        if (valid && ready) pop0();
        if (valid6 && ready6) pop6();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_counter0(input int target);
        int n = 0;
        while (int'(counter) != target && n < 8) begin
            tick();
            n++;
        end
        chk("wait_counter0", 32'(counter), 32'(target));
    endtask

    task automatic wait_counter6(input int target);
        int n = 0;
        while (int'(counter6) != target && n < 8) begin
            tick();
            n++;
        end
        chk("wait_counter6", 32'(counter6), 32'(target));
    endtask

    task automatic wait_valid0();
        int n = 0;
        while (!valid && n < 8) begin
            tick();
            n++;
        end
        chk("wait_valid0", 32'(valid), 32'd1);
    endtask

    task automatic push0(input int d, input int g);
        sb0.push_back('{16'(d), g});
    endtask

    task automatic push6(input int d, input int g);
        sb6.push_back('{16'(d), g});
    endtask

    initial begin
        rst_n  = 1'b1;
        wen    = '0;
        din    = '0;
        ready  = 1'b0;
        wen6   = '0;
        din6   = '0;
        ready6 = 1'b0;

        // Reset values, taken asynchronously before any clock edge
        #1 rst_n = 1'b0;
        #2;
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_counter", 32'(counter), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_counter6", 32'(counter6), 32'd0);
        chk("rst_valid6", 32'(valid6), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: one word per channel drains in channel order
        ready = 1'b1;
        wait_counter0(SYNC0);
        wen = 4'b1111;
        din = {8'd12, 8'd9, 8'd56, 8'd87};
        push0(87, 0);
        push0(56, 1);
        push0(9, 2);
        push0(12, 3);
        tick();
        wen = '0;
        repeat (5) tick();
        chk("t1_valid_low", 32'(valid), 32'd0);
        chk("t1_sb_empty", 32'(sb0.size()), 32'd0);

        // 2: only channel 3 holds data, pointer at 0 when it becomes poppable
        wait_counter0(SYNC0);
        wen = 4'b1000;
        din = {8'd85, 24'd0};
        push0(85, 3);
        tick();
        wen = '0;
        for (int k = 0; k < NBUB; k++) begin
            tick();
            chk("t2_bubble_valid", 32'(valid), 32'd0);
        end
        tick();
        chk("t2_valid", 32'(valid), 32'd1);
        chk("t2_dout", 32'(dout), 32'd85);
        chk("t2_grant", 32'(grant_id), 32'd3);
        chk("t2_counter", 32'(counter), 32'd0);
        repeat (2) tick();
        chk("t2_sb_empty", 32'(sb0.size()), 32'd0);

        // 3: fill channel 0 behind a stalled output, overflow, then drain in order
        ready = 1'b0;
        wen = 4'b0010;
        din = {16'd0, 8'h21, 8'd0};
        push0(8'h21, 1);
        tick();
        wen = '0;
        wait_valid0();
        chk("t3_stall_dout", 32'(dout), 32'h21);
        wen = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            din = {24'd0, 8'(10 + k)};
            if (k < 4) push0(10 + k, 0);
            tick();
            if (k == 2) chk("t3_full_after3", 32'(full), 32'b0000);
            if (k == 3) chk("t3_full_after4", 32'(full), 32'b0001);
            if (k == 3) chk("t3_ovf_after4", 32'(ovf), 32'b0000);
        end
        chk("t3_ovf_pulse", 32'(ovf), 32'b0001);
        chk("t3_full_after5", 32'(full), 32'b0001);
        wen = '0;
        tick();
        chk("t3_ovf_cleared", 32'(ovf), 32'b0000);
        ready = 1'b1;
        repeat (20) tick();
        chk("t3_sb_empty", 32'(sb0.size()), 32'd0);
        chk("t3_full_drained", 32'(full), 32'b0000);

        // 4: backpressure holds the output while new data queues behind it
        ready = 1'b0;
        wen = 4'b0010;
        din = {16'd0, 8'h56, 8'd0};
        push0(8'h56, 1);
        tick();
        wen = '0;
        wait_valid0();
        push0(8'h77, 2);
        push0(8'h78, 2);
        for (int k = 0; k < 5; k++) begin
            wen = (k < 2) ? 4'b0100 : 4'b0000;
            din = {8'd0, 8'(8'h77 + k), 16'd0};
            tick();
            chk("t4_stall_valid", 32'(valid), 32'd1);
            chk("t4_stall_dout", 32'(dout), 32'h56);
            chk("t4_stall_grant", 32'(grant_id), 32'd1);
            chk("t4_stall_counter", 32'(counter), 32'd2);
        end
        wen = '0;
        ready = 1'b1;
        repeat (12) tick();
        chk("t4_sb_empty", 32'(sb0.size()), 32'd0);

        // 5: asynchronous reset with data queued, then idle until new writes
        ready = 1'b0;
        wen = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            din = {24'd0, 8'(8'hA0 + k)};
            tick();
        end
        wen = '0;
        wait_valid0();
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_dout", 32'(dout), 32'd0);
        chk("t5_rst_valid", 32'(valid), 32'd0);
        chk("t5_rst_grant", 32'(grant_id), 32'd0);
        chk("t5_rst_counter", 32'(counter), 32'd0);
        chk("t5_rst_full", 32'(full), 32'd0);
        chk("t5_rst_ovf", 32'(ovf), 32'd0);
        sb0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t5_idle_valid", 32'(valid), 32'd0);
        end
        wen = 4'b0100;
        din = {8'd0, 8'h5A, 16'd0};
        push0(8'h5A, 2);
        tick();
        wen = '0;
        repeat (8) tick();
        chk("t5_sb_empty", 32'(sb0.size()), 32'd0);

        // 6: three channels, 16-bit data, pointer wraps 2 -> 0
        ready6 = 1'b1;
        wait_counter6(SYNC6);
        wen6 = 3'b111;
        din6 = {16'h3333, 16'h1111, 16'hBEEF};
        push6(16'hBEEF, 0);
        push6(16'h1111, 1);
        push6(16'h3333, 2);
        push6(16'h0001, 0);
        push6(16'h2222, 1);
        push6(16'h4444, 2);
        tick();
        din6 = {16'h4444, 16'h2222, 16'h0001};
        tick();
        wen6 = '0;
        repeat (12) tick();
        chk("t6_sb_empty", 32'(sb6.size()), 32'd0);
        chk("t6_valid_low", 32'(valid6), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
